jump_unit: RTL and testbench

Control-flow resolution stage directly upstream of the program counter. Accepts one resolved control-flow request per cycle from execute and drives the counter's `Jump`/`JumpTo` inputs. Computes branch targets. Maintains a return-address stack (RAS) for call/return. Squashes wrong-path requests fetched behind a taken jump.

---
 rtl/jump_unit_pkg.sv | 9 +
 rtl/ras_stack.sv | 40 ++++
 rtl/jump_unit.sv | 67 ++++++
 tb/tb_jump_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/jump_unit_pkg.sv
// jump_unit_pkg: request kinds, FSM state type and the default address width shared with the program counter
package jump_unit_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam logic [1:0] KIND_BR   = 2'd0;
  localparam logic [1:0] KIND_JMP  = 2'd1;
  localparam logic [1:0] KIND_CALL = 2'd2;
  localparam logic [1:0] KIND_RET  = 2'd3;
  typedef enum logic {RUN, SQUASH} state_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO (push/pop/push_data in; top, empty, full, overflow/underflow pulses out)
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, top_idx;
  logic [PW:0] count;
  assign top_idx = ptr - 1'b1;
  assign top = mem[top_idx];
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign overflow = push && full;
  assign underflow = pop && empty;
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      ptr <= top_idx;
      count <= count - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[ptr] <= push_data;
endmodule

// File: rtl/jump_unit.sv
// jump_unit: resolves control-flow requests into registered Jump/JumpTo, keeps a RAS, squashes wrong-path requests
module jump_unit
  import jump_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RAS_DEPTH = 8,
  parameter int SHADOW = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  input  logic [1:0]        req_kind,
  input  logic              req_taken,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic [ADDR_W-1:0] req_target,
  output logic              Jump,
  output logic [ADDR_W-1:0] JumpTo,
  output logic              ras_overflow,
  output logic              ras_underflow
);
  localparam int CW = $clog2(SHADOW + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic eff, taking, push, pop, empty, full, ovf_ev, unf_ev;
  logic [ADDR_W-1:0] top, target, ret_addr;
  assign eff = req_valid && state == RUN;
  assign taking = eff && (req_kind != KIND_BR || req_taken);
  assign push = eff && req_kind == KIND_CALL;
  assign pop = eff && req_kind == KIND_RET;
  assign ret_addr = req_pc + 1'b1;
  always_comb
    target = req_kind == KIND_BR ? req_pc + req_target :
             req_kind == KIND_RET ? (empty ? '0 : top) : req_target;
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .Reset_n(Reset_n),
    .push(push),
    .pop(pop),
    .push_data(ret_addr),
    .top(top),
    .empty(empty),
    .full(full),
    .overflow(ovf_ev),
    .underflow(unf_ev)
  );
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= RUN;
      cnt <= '0;
      Jump <= 1'b0;
      JumpTo <= '0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      Jump <= taking;
      if (taking) JumpTo <= target;
      ras_overflow <= ras_overflow || (ovf_ev && full);
      ras_underflow <= ras_underflow || unf_ev;
      if (state == RUN) begin
        if (taking) begin
          state <= SQUASH;
          cnt <= CW'(SHADOW);
        end
      end else if (cnt == CW'(1)) state <= RUN;
      else cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_jump_unit.sv
// tb_jump_unit: directed and randomized checks of jump_unit against a queue-based reference model
module tb_jump_unit;
  import jump_unit_pkg::*;
  localparam int AW = 10;
  localparam int SH = 2;
  localparam int DEP = 8;
  logic clk = 0, Reset_n = 0, req_valid = 0, req_taken = 0;
  logic [1:0] req_kind = 0;
  logic [AW-1:0] req_pc = 0, req_target = 0;
  logic Jump, ras_overflow, ras_underflow;
  logic [AW-1:0] JumpTo;
  int checks = 0, errors = 0;
  logic [AW-1:0] ras_q[$];
  int sq;
  logic m_jump, m_ovf, m_unf;
  logic [AW-1:0] m_to;
  always #5 clk = ~clk;
  jump_unit #(.ADDR_W(AW), .RAS_DEPTH(DEP), .SHADOW(SH)) dut (
    .clk(clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_kind(req_kind),
    .req_taken(req_taken), .req_pc(req_pc), .req_target(req_target),
    .Jump(Jump), .JumpTo(JumpTo), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );
  task automatic model_reset();
    ras_q.delete();
    sq = 0;
    m_jump = 0;
    m_to = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask
  task automatic cyc(input logic v, input logic [1:0] k, input logic t, input logic [AW-1:0] pc, input logic [AW-1:0] tg);
    logic [AW-1:0] tgt;
    req_valid = v;
    req_kind = k;
    req_taken = t;
    req_pc = pc;
    req_target = tg;
    @(posedge clk);
    m_jump = 0;
    if (sq > 0) sq--;
    else if (v) begin
      tgt = tg;
      if (k == KIND_BR) tgt = pc + tg;
      else if (k == KIND_CALL) begin
        if (ras_q.size() == DEP) begin
          void'(ras_q.pop_front());
          m_ovf = 1;
        end
        ras_q.push_back(pc + AW'(1));
      end else if (k == KIND_RET) begin
        if (ras_q.size() == 0) begin
          tgt = 0;
          m_unf = 1;
        end else tgt = ras_q.pop_back();
      end
      if (k != KIND_BR || t) begin
        m_jump = 1;
        m_to = tgt;
        sq = SH;
      end
    end
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 2'd0, 0, '0, '0);
  endtask
  task automatic do_reset();
    req_valid = 0;
    #3 Reset_n = 0;
    #1 model_reset();
    checks++; if (Jump !== 1'b0) begin errors++; $display("FAIL rst_jump got=%b exp=0", Jump); end
    checks++; if (JumpTo !== '0) begin errors++; $display("FAIL rst_jumpto got=%h exp=000", JumpTo); end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", ras_overflow, ras_underflow); end
    @(negedge clk) Reset_n = 1;
    idle(1);
  endtask
  task automatic test_reset();
    do_reset();
    cyc(1, KIND_JMP, 0, 10'h020, 10'h155);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h155) begin errors++; $display("FAIL pre_rst_jmp got=%b/%h exp=1/155", Jump, JumpTo); end
    do_reset();
  endtask
  task automatic test_branch();
    cyc(1, KIND_BR, 1, 10'h3FE, 10'h005);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h003) begin errors++; $display("FAIL br_wrap got=%b/%h exp=1/003", Jump, JumpTo); end
    idle(1);
    checks++; if (Jump !== 1'b0) begin errors++; $display("FAIL br_one_cycle got=%b exp=0", Jump); end
    idle(1);
    cyc(1, KIND_BR, 0, 10'h3FE, 10'h005);
    checks++; if (Jump !== 1'b0 || JumpTo !== 10'h003) begin errors++; $display("FAIL br_not_taken got=%b/%h exp=0/003", Jump, JumpTo); end
    cyc(1, KIND_JMP, 0, 10'h000, 10'h042);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h042) begin errors++; $display("FAIL after_nt got=%b/%h exp=1/042", Jump, JumpTo); end
    idle(2);
  endtask
  task automatic test_squash();
    cyc(1, KIND_JMP, 0, 10'h000, 10'h100);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h100) begin errors++; $display("FAIL sq_first got=%b/%h exp=1/100", Jump, JumpTo); end
    for (int i = 0; i < SH; i++) begin
      cyc(1, KIND_JMP, 0, 10'h000, 10'h200);
      checks++; if (Jump !== 1'b0 || JumpTo !== 10'h100) begin errors++; $display("FAIL sq_shadow%0d got=%b/%h exp=0/100", i, Jump, JumpTo); end
    end
    cyc(1, KIND_JMP, 0, 10'h000, 10'h200);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h200) begin errors++; $display("FAIL sq_third got=%b/%h exp=1/200", Jump, JumpTo); end
    idle(2);
    cyc(1, KIND_RET, 0, 10'h000, 10'h000);
    checks++; if (JumpTo !== 10'h000 || ras_underflow !== 1'b1) begin errors++; $display("FAIL sq_ras_empty got=%h/%b exp=000/1", JumpTo, ras_underflow); end
    idle(2);
    do_reset();
  endtask
  task automatic test_call_ret();
    cyc(1, KIND_CALL, 0, 10'h010, 10'h080);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h080) begin errors++; $display("FAIL call got=%b/%h exp=1/080", Jump, JumpTo); end
    idle(3);
    cyc(1, KIND_RET, 0, 10'h3AA, 10'h2BB);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h011) begin errors++; $display("FAIL ret got=%b/%h exp=1/011", Jump, JumpTo); end
    checks++; if (ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin errors++; $display("FAIL callret_flags got=%b%b exp=00", ras_overflow, ras_underflow); end
    idle(2);
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(1, KIND_CALL, 0, AW'(i), AW'(10'h200 + i));
      if (i == 7) begin
        checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", ras_overflow); end
      end
      idle(2);
    end
    checks++; if (ras_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ras_overflow); end
    for (int j = 0; j < 9; j++) begin
      cyc(1, KIND_RET, 0, '0, '0);
      checks++; if (Jump !== 1'b1 || JumpTo !== (j < 8 ? AW'(9 - j) : AW'(0))) begin errors++; $display("FAIL ret%0d got=%b/%h exp=1/%h", j, Jump, JumpTo, (j < 8 ? AW'(9 - j) : AW'(0))); end
      if (j == 7) begin
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL unf_early got=%b exp=0", ras_underflow); end
      end
      idle(2);
    end
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL unf_set got=%b exp=1", ras_underflow); end
  endtask
  task automatic test_reset_squash();
    do_reset();
    cyc(1, KIND_CALL, 0, 10'h123, 10'h321);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h321) begin errors++; $display("FAIL rs_call got=%b/%h exp=1/321", Jump, JumpTo); end
    do_reset();
    cyc(1, KIND_RET, 0, '0, '0);
    checks++; if (Jump !== 1'b1 || JumpTo !== 10'h000 || ras_underflow !== 1'b1) begin errors++; $display("FAIL rs_ret got=%b/%h/%b exp=1/000/1", Jump, JumpTo, ras_underflow); end
    idle(2);
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom));
      checks++; if (Jump !== m_jump || JumpTo !== m_to) begin errors++; $display("FAIL rnd%0d_jump got=%b/%h exp=%b/%h", n, Jump, JumpTo, m_jump, m_to); end
      checks++; if (ras_overflow !== m_ovf || ras_underflow !== m_unf) begin errors++; $display("FAIL rnd%0d_flags got=%b%b exp=%b%b", n, ras_overflow, ras_underflow, m_ovf, m_unf); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_squash();
    test_call_ret();
    test_overflow();
    test_reset_squash();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
